// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: hunts 0xBC comma alignment, locks after LOCK_COUNT aligned commas.
// Latency: byte visible one edge after its last bit is sampled; outputs hold for 8 edges.
// Backpressure: none; the line runs at clk_8f and the downstream stage must sample every boundary.
// Optional build macro SP_IDLE_DATA_EN: idle commas in ACTIVE drive data_out=COMMA instead of holding.
module serial_paralelo_rx #(
   parameter logic [7:0]  COMMA      = 8'hBC,
   parameter int unsigned LOCK_COUNT = 4      // 2..15
) (
   input  logic       clk_8f,
   input  logic       reset,      // synchronous, active-low
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      LOCKING = 2'd1,
      ACTIVE  = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

   state_t     state_q, state_d;
   // Only the last 7 line bits are needed; the 8th comes straight from data_in.
   logic [6:0] sr_q, sr_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] bc_cnt_q, bc_cnt_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       active_q, active_d;

   logic [7:0] cand;
   logic       is_comma;
   logic       boundary;
   logic [3:0] bc_inc;

   assign cand     = {sr_q, data_in};
   assign is_comma = (cand == COMMA);
   assign boundary = (bit_cnt_q == 3'd7);
   assign bc_inc   = bc_cnt_q + 4'd1;

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk_8f) begin
      if (!reset) begin
         state_q   <= SEARCH;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         bc_cnt_q  <= '0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         bc_cnt_q  <= bc_cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         active_q  <= active_d;
      end
   end

   // Next-state: alignment hunt, lock counting, and byte presentation at boundaries.
   always_comb begin
      state_d   = state_q;
      sr_d      = cand[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      bc_cnt_d  = bc_cnt_q;
      data_d    = data_q;
      valid_d   = valid_q;
      active_d  = active_q;
      case (state_q)
         SEARCH: begin
            // Bit-level hunt: any 8-bit window equal to the comma sets alignment.
            bit_cnt_d = 3'd0;
            if (is_comma) begin
               state_d  = LOCKING;
               bc_cnt_d = 4'd1;
            end
         end
         LOCKING: begin
            if (boundary) begin
               if (is_comma) begin
                  bc_cnt_d = bc_inc;
                  if (bc_inc == LOCK_CNT) begin
                     state_d  = ACTIVE;
                     active_d = 1'b1;
                  end
               end else begin
                  state_d  = SEARCH;
                  bc_cnt_d = 4'd0;
               end
            end
         end
         ACTIVE: begin
            // Lock loss is not tracked; only reset leaves this state.
            if (boundary) begin
               if (is_comma) begin
                  valid_d = 1'b0;
`ifdef SP_IDLE_DATA_EN
                  data_d  = COMMA;
`else
                  data_d  = data_q;
`endif
               end else begin
                  data_d  = cand;
                  valid_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = SEARCH;
         end
      endcase
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign active    = active_q;

endmodule
